gpio_irq_ctrl: RTL



---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_prio_enc.sv | 23 ++
 rtl/gpio_irq_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller slice.
package gpio_pkg;

   // Default pin count for GPIO blocks in this codebase.
   localparam int GPIO_N_GPIOS = 8;

   // Interrupt controller service states.
   typedef enum logic [1:0] {
      GPIO_IRQ_IDLE = 2'd0,
      GPIO_IRQ_PEND = 2'd1,
      GPIO_IRQ_SERV = 2'd2
   } gpio_irq_state_e;

endpackage

// File: rtl/gpio_prio_enc.sv
// Lowest-index priority encoder: reports whether any request is set and the
// index of the lowest set bit (0 when none is set).
module gpio_prio_enc #(
   parameter int N   = 8,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   output logic           valid,
   output logic [IDW-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: latches per-pin pulses into pending bits, masks
// them, and hands the lowest eligible pin to the CPU through a claim/complete
// handshake guarded by a service watchdog. One interrupt in service at a time.
module gpio_irq_ctrl
   import gpio_pkg::*;
#(
   parameter int N_GPIOS = GPIO_N_GPIOS,
   parameter int TIMEOUT = 1024,
   parameter int IDW     = (N_GPIOS > 1) ? $clog2(N_GPIOS) : 1
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic [N_GPIOS-1:0] irq_i,
   input  logic [N_GPIOS-1:0] mask_i,
   output logic               irq_o,
   output logic [N_GPIOS-1:0] pending_o,
   input  logic               claim_req_i,
   output logic               claim_ack_o,
   output logic               claim_valid_o,
   output logic [IDW-1:0]     claim_id_o,
   input  logic               complete_i,
   input  logic [IDW-1:0]     complete_id_i,
   input  logic               clear_i,
   output logic               err_o,
   output logic               timeout_o
);

   // Watchdog counter only needs to reach TIMEOUT-1; a zero TIMEOUT disables it.
   localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   gpio_irq_state_e      state_q;
   gpio_irq_state_e      state_n;
   logic [N_GPIOS-1:0]   pending_q;
   logic [N_GPIOS-1:0]   pending_n;
   logic [N_GPIOS-1:0]   elig;
   logic [N_GPIOS-1:0]   claim_clr;
   logic [IDW-1:0]       svc_id_q;
   logic [WDW-1:0]       wd_q;
   logic                 wd_exp;
   logic                 enc_valid;
   logic [IDW-1:0]       enc_idx;
   logic                 claim_ok;
   logic                 cmp_match;
   logic                 wd_fire;
   logic                 err_set;

   assign elig = pending_q & mask_i;

   gpio_prio_enc #(
      .N   (N_GPIOS),
      .IDW (IDW)
   ) u_prio_enc (
      .req   (elig),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   assign wd_exp = (TIMEOUT != 0) && (state_q == GPIO_IRQ_SERV) && (wd_q == WD_LAST);

   // Next-state decode: claims are only honoured outside SERV; in SERV a
   // matching completion takes precedence over a watchdog expiry.
   always_comb begin
      state_n   = state_q;
      claim_ok  = 1'b0;
      cmp_match = 1'b0;
      wd_fire   = 1'b0;
      case (state_q)
         GPIO_IRQ_IDLE: begin
            if (claim_req_i && enc_valid) begin
               claim_ok = 1'b1;
               state_n  = GPIO_IRQ_SERV;
            end else if (enc_valid) begin
               state_n = GPIO_IRQ_PEND;
            end
         end
         GPIO_IRQ_PEND: begin
            if (claim_req_i && enc_valid) begin
               claim_ok = 1'b1;
               state_n  = GPIO_IRQ_SERV;
            end else if (!enc_valid) begin
               state_n = GPIO_IRQ_IDLE;
            end
         end
         GPIO_IRQ_SERV: begin
            if (complete_i && (complete_id_i == svc_id_q)) begin
               cmp_match = 1'b1;
               state_n   = GPIO_IRQ_IDLE;
            end else if (wd_exp) begin
               wd_fire = 1'b1;
               state_n = GPIO_IRQ_IDLE;
            end
         end
         default: state_n = GPIO_IRQ_IDLE;
      endcase
   end

   // Any completion that does not close the current service is an error.
   assign err_set = complete_i && !cmp_match;

   // A fresh pulse beats the claim clear on the same bit.
   always_comb begin
      claim_clr = '0;
      if (claim_ok) begin
         claim_clr = N_GPIOS'(1) << enc_idx;
      end
      pending_n = (pending_q & ~claim_clr) | irq_i;
   end

   // State, pending bits and in-service id.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= GPIO_IRQ_IDLE;
         pending_q <= '0;
         svc_id_q  <= '0;
      end else begin
         state_q   <= state_n;
         pending_q <= pending_n;
         if (claim_ok) begin
            svc_id_q <= enc_idx;
         end
      end
   end

   // Watchdog counts consecutive SERV cycles and restarts whenever SERV is left.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wd_q <= '0;
      end else if ((state_q == GPIO_IRQ_SERV) && (state_n == GPIO_IRQ_SERV)) begin
         wd_q <= wd_q + 1'b1;
      end else begin
         wd_q <= '0;
      end
   end

   // Registered one-cycle claim response; an empty claim returns id 0.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         claim_ack_o   <= 1'b0;
         claim_valid_o <= 1'b0;
         claim_id_o    <= '0;
      end else begin
         claim_ack_o   <= claim_req_i;
         claim_valid_o <= claim_ok;
         claim_id_o    <= claim_ok ? enc_idx : '0;
      end
   end

   // Sticky flags: a new event in the same cycle as clear_i keeps the flag set.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         err_o     <= err_set | (err_o & ~clear_i);
         timeout_o <= wd_fire | (timeout_o & ~clear_i);
      end
   end

   assign irq_o     = (state_q == GPIO_IRQ_PEND);
   assign pending_o = pending_q;

endmodule
